// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling on tick_rx, 5..8 data bits,
// optional even/odd parity and one or two stop bits, one-clk rx_valid_o per frame.
module uart_rx #(
  parameter int SAMPLING_RATE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_rx,
  input  logic       rx_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop2_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CW = (SAMPLING_RATE > 1) ? $clog2(SAMPLING_RATE) : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(SAMPLING_RATE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(SAMPLING_RATE / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic            sync1, sync2, line_prev;
  logic [CW-1:0]   tick_cnt;
  logic [2:0]      bit_cnt;
  logic            stop_cnt;
  logic [7:0]      shreg;
  logic            par_pend, fe_pend;
  logic [1:0]      data_bits_q;
  logic            parity_en_q, parity_odd_q, stop2_q;
  logic            start_go, half_hit, bit_hit, last_data, last_stop;

  // Starts are ignored during the rx_valid_o cycle so a frame always sees one idle clk first.
  assign start_go  = (state == IDLE) && line_prev && !sync2 && !rx_valid_o;
  assign half_hit  = tick_rx && (tick_cnt == HALF_LAST);
  assign bit_hit   = tick_rx && (tick_cnt == FULL_LAST);
  assign last_data = (bit_cnt == ({1'b0, data_bits_q} + 3'd4));
  assign last_stop = (state == STOP) && bit_hit && (stop_cnt || !stop2_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= rx_i;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = START;
      START:   if (half_hit) state_nxt = sync2 ? IDLE : DATA;
      DATA:    if (bit_hit && last_data) state_nxt = parity_en_q ? PARITY : STOP;
      PARITY:  if (bit_hit) state_nxt = STOP;
      STOP:    if (last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
  end

  // The start phase wraps at half a bit so every later sample lands mid-bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (state == IDLE) begin
      tick_cnt <= '0;
    end else if (tick_rx) begin
      if (((state == START) && (tick_cnt == HALF_LAST)) || (tick_cnt == FULL_LAST))
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_bits_q  <= 2'b00;
      parity_en_q  <= 1'b0;
      parity_odd_q <= 1'b0;
      stop2_q      <= 1'b0;
      shreg        <= 8'h00;
      bit_cnt      <= 3'd0;
      stop_cnt     <= 1'b0;
      par_pend     <= 1'b0;
      fe_pend      <= 1'b0;
    end else if (start_go) begin
      data_bits_q  <= data_bits_i;
      parity_en_q  <= parity_en_i;
      parity_odd_q <= parity_odd_i;
      stop2_q      <= stop2_i;
      shreg        <= 8'h00;
      bit_cnt      <= 3'd0;
      stop_cnt     <= 1'b0;
      par_pend     <= 1'b0;
      fe_pend      <= 1'b0;
    end else if (bit_hit) begin
      case (state)
        DATA: begin
          shreg[bit_cnt] <= sync2;
          bit_cnt        <= bit_cnt + 3'd1;
        end
        PARITY: par_pend <= (^shreg) ^ sync2 ^ parity_odd_q;
        STOP: begin
          stop_cnt <= 1'b1;
          if (!sync2) fe_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid_o   <= 1'b0;
      rx_data_o    <= 8'h00;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_valid_o <= last_stop;
      if (last_stop) begin
        rx_data_o    <= shreg;
        parity_err_o <= par_pend;
        frame_err_o  <= fe_pend | ~sync2;
      end
    end
  end

endmodule
